// File: rtl/clk_div_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_div_bank: CH programmable 50%-duty dividers + free-run counter    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module clk_div_bank #(
  parameter int CH      = 4,
  parameter int DW      = 16,
  parameter int CNT_W   = 32,
  parameter int CHW     = 2,
  parameter int DIV_RST = 0
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [CH-1:0]    ch_en,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [DW-1:0]    cfg_div,
  output logic             cfg_err,
  output logic [CH-1:0]    pend,
  output logic [CNT_W-1:0] clkdiv,
  output logic [CH-1:0]    clk_out,
  output logic [CH-1:0]    tick
);

  localparam logic [DW-1:0] c_DIV_RST = DW'(DIV_RST);
  localparam logic [CHW:0]  c_CH      = (CHW + 1)'(CH);

  logic w_bad_ch;
  assign w_bad_ch = ({1'b0, cfg_ch} >= c_CH);

  always_ff @(posedge clk) begin
    if (RST) begin
      clkdiv  <= '0;
      cfg_err <= 1'b0;
    end else begin
      clkdiv  <= clkdiv + CNT_W'(1);
      cfg_err <= cfg_we && w_bad_ch;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [DW-1:0] r_cnt;
    logic [DW-1:0] r_div_cur;
    logic [DW-1:0] r_div_pend;
    logic          r_pend;
    logic          r_clk;
    logic          r_tick;
    logic          w_wr;
    logic          w_wrap;

    assign w_wr   = cfg_we && (cfg_ch == CHW'(i));
    assign w_wrap = (r_cnt == r_div_cur);

    always_ff @(posedge clk) begin
      if (RST) begin
        r_cnt      <= '0;
        r_div_cur  <= c_DIV_RST;
        r_div_pend <= c_DIV_RST;
        r_pend     <= 1'b0;
        r_clk      <= 1'b0;
        r_tick     <= 1'b0;
      end else begin
        if (!ch_en[i]) begin
          r_cnt  <= '0;
          r_clk  <= 1'b0;
          r_tick <= 1'b0;
          if (r_pend) begin
            r_div_cur <= r_div_pend;
            r_pend    <= 1'b0;
          end
        end else if (w_wrap) begin
          r_cnt  <= '0;
          r_clk  <= ~r_clk;
          r_tick <= ~r_clk;
          // Ratio only changes at the falling transition, i.e. a period boundary
          if (r_clk && r_pend) begin
            r_div_cur <= r_div_pend;
            r_pend    <= 1'b0;
          end
        end else begin
          r_cnt  <= r_cnt + DW'(1);
          r_tick <= 1'b0;
        end
        // A write wins over a same-cycle switchover clear; div_cur took the old value
        if (w_wr) begin
          r_div_pend <= cfg_div;
          r_pend     <= 1'b1;
        end
      end
    end

    assign pend[i]    = r_pend;
    assign clk_out[i] = r_clk;
    assign tick[i]    = r_tick;
  end

endmodule
`default_nettype wire

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of CH independent programmable clock dividers with a shared free-running cycle counter, all driven from one system clock. Each channel produces a 50 %-duty divided clock level and a one-cycle tick enable. Divide ratios can be reprogrammed at run time with glitch-free, period-aligned switchover. The block sits directly behind the board clock buffer and feeds slow peripherals (display scan, debounce, UART baud, CPU single-step) with clock enables, replacing ad-hoc `clkdiv[n]` taps.

## Interface
- `CH`, 4: number of divider channels (1..16).
- `DW`, 16: width of each divide-ratio field.
- `CNT_W`, 32: width of the free-running counter.
- `CHW`, 2: width of the channel select; must satisfy 2^CHW >= CH.
- `DIV_RST`, 0: divide value loaded into every channel at reset.

- `clk`  in  1  system clock; all logic on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `ch_en`  in  CH  per-channel run enable.
- `cfg_we`  in  1  one-cycle write strobe for a new divide value.
- `cfg_ch`  in  CHW  target channel of the write.
- `cfg_div`  in  DW  new divide value D.
- `cfg_err`  out  1  one-cycle pulse; the write addressed `cfg_ch >= CH`.
- `pend`  out  CH  per-channel flag; a written value awaits switchover.
- `clkdiv`  out  CNT_W  free-running cycle counter.
- `clk_out`  out  CH  divided clock level per channel.
- `tick`  out  CH  one-cycle pulse per divided period per channel.

## Operation
- `clkdiv` increments by 1 every cycle and wraps from 2^CNT_W−1 to 0. It is not gated by `ch_en`.
- Per-channel state: `cnt[DW]`, `div_cur[DW]`, `div_pend[DW]`, `pend`, `clk_out`, `tick`.
- **Running channel** (`ch_en[i]`=1), each cycle:
  - If `cnt == div_cur`:
    - `cnt` <= 0.
    - `clk_out` <= ~`clk_out`.
    - `tick` <= ~`clk_out` (pulses on the rising transition only).
  - Otherwise: `cnt` <= `cnt`+1 and `tick` <= 0.
- Resulting output: `clk_out` period = 2·(D+1) cycles at 50 % duty. D=0 gives clk/2. `tick` fires once per period, in the first high cycle of `clk_out`.
- **Switchover:** on a wrap with `clk_out`=1 (the falling transition, end of a full period), if `pend`=1 then `div_cur` <= `div_pend` and `pend` <= 0. A running channel never changes ratio mid-period.
- **Disabled channel** (`ch_en[i]`=0):
  - `cnt`, `clk_out` and `tick` are forced to 0 on the next edge.
  - If `pend`=1, apply the pending value immediately.
- **Re-enable:** counting restarts from `cnt`=0, `clk_out`=0. The first rising `clk_out` (with `tick`) is registered D+1 cycles after the first enabled cycle.
- **Config write** (`cfg_we`=1):
  - If `cfg_ch < CH`: `div_pend[cfg_ch]` <= `cfg_div` and `pend[cfg_ch]` <= 1.
  - If `cfg_ch >= CH`: no state changes and `cfg_err` <= 1 for one cycle.
- **Write while pending:** overwrites `div_pend`; the last value written before switchover wins.
- **Write in the same cycle as switchover on that channel:** `div_cur` takes the old `div_pend`. The new value lands in `div_pend` and `pend` stays 1.
- A write of the value already in `div_cur` still sets `pend`. It is harmless and cleared at the next falling transition.

## Timing
- Reset (`RST` sampled high), effective the next edge:
  - `clkdiv`=0, `clk_out`=0, `tick`=0, `pend`=0, `cfg_err`=0.
  - `cnt`=0, `div_cur`=`div_pend`=DIV_RST for every channel.
- `RST` overrides `cfg_we` and `ch_en` in the same cycle.
- Reset mid-period truncates the output with no extra pulse.
- All outputs are registered, with no combinational path from inputs to outputs.
- `pend` rises 1 cycle after `cfg_we`. `cfg_err` is high exactly 1 cycle after the bad write.
- Switchover latency for a running channel is at most 2·(D_old+1) cycles after the write.
- The first full period at the new ratio starts at the rising transition immediately after switchover.

## Test plan
- **Reset and free-run:** hold `RST` 3 cycles, then release with `ch_en`=0 → all outputs 0; `clkdiv` counts 0,1,2,… from release; with CNT_W=4, `clkdiv` wraps 15→0.
- **Basic divide:** DIV_RST=0, set `ch_en[0]`=1 → `clk_out[0]` toggles every cycle, period 2. Write D=2 to ch1 and enable it → period 6, high 3 cycles, exactly one `tick` per period, coincident with the first high cycle.
- **Glitch-free switch:** ch2 running with D=4; mid-high-phase write D=1 → the current period completes at 10 cycles, `pend` clears on the falling edge, and subsequent periods are 4 cycles with no short pulse.
- **Back-to-back writes:** write D=7 then D=3 to ch3 on consecutive cycles while running → only D=3 is applied. Separately, a write landing in the exact switchover cycle → old pend applied and `pend` stays 1.
- **Disable/re-enable:** drop `ch_en[1]` mid-period → `clk_out[1]`=0 next cycle. Write D=5 while disabled → `pend` clears next cycle. Re-enable → first `tick` 6 cycles after the first enabled cycle.
- **Bad address:** CH=3, write `cfg_ch`=3 → `cfg_err` pulses 1 cycle, all `pend` remain 0, and all ratios are unchanged.
